// File: rtl/tr_seq_gen.sv
// Transaction sequencer: takes one command at a time, optionally pulses a DUT
// soft reset, then streams a counted valid/ready burst on one of NUM_CH channels.
module tr_seq_gen #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RST_CYCLES = 1,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [CNT_W-1:0]           cmd_b,
  input  logic [CH_W-1:0]            cmd_ch,
  input  logic [1:0]                 cmd_mode,
  input  logic                       cmd_rst,
  output logic                       dut_resetn,
  output logic [NUM_CH-1:0]          tr_valid,
  input  logic [NUM_CH-1:0]          tr_ready,
  output logic [NUM_CH*DATA_W-1:0]   tr_data,
  output logic [NUM_CH-1:0]          tr_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] cur;
  logic [CNT_W-1:0]  remaining;
  logic [CH_W-1:0]   ch_q;
  logic [1:0]        mode_q;
  logic [RC_W-1:0]   rst_cnt;
  logic [CH_W-1:0]   ch_sel;
  logic [DATA_W-1:0] nxt_val;
  logic              accept;

  // Out-of-range channel requests land on the highest channel
  always_comb begin
    ch_sel = cmd_ch;
    if (32'(cmd_ch) > NUM_CH - 1) ch_sel = CH_W'(NUM_CH - 1);
  end

  // Value for the beat following an accepted one; reserved mode behaves as CONST
  always_comb begin
    nxt_val = cur;
    case (mode_q)
      2'd0:    nxt_val = cur + DATA_W'(1);
      2'd2:    nxt_val = cur - DATA_W'(1);
      default: nxt_val = cur;
    endcase
  end

  assign accept = cmd_valid && cmd_ready && (state == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      dut_resetn <= 1'b0;
      tr_valid   <= '0;
      tr_data    <= '0;
      tr_last    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur        <= '0;
      remaining  <= '0;
      ch_q       <= '0;
      mode_q     <= '0;
      rst_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready  <= 1'b1;
          dut_resetn <= 1'b1;
          if (accept) begin
            cur       <= cmd_a;
            remaining <= cmd_b;
            ch_q      <= ch_sel;
            mode_q    <= cmd_mode;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_rst) begin
              state      <= S_RST;
              dut_resetn <= 1'b0;
              rst_cnt    <= RC_W'(RST_CYCLES - 1);
            end else if (cmd_b != '0) begin
              state                               <= S_RUN;
              tr_valid[ch_sel]                    <= 1'b1;
              tr_data[ch_sel*DATA_W +: DATA_W]    <= cmd_a;
              tr_last[ch_sel]                     <= (cmd_b == CNT_W'(1));
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RST: begin
          if (rst_cnt == '0) begin
            dut_resetn <= 1'b1;
            if (remaining != '0) begin
              state                           <= S_RUN;
              tr_valid[ch_q]                  <= 1'b1;
              tr_data[ch_q*DATA_W +: DATA_W]  <= cur;
              tr_last[ch_q]                   <= (remaining == CNT_W'(1));
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end
        S_RUN: begin
          // Data and last only move on an accepted beat, so they hold across stalls
          if (tr_ready[ch_q]) begin
            if (remaining == CNT_W'(1)) begin
              tr_valid <= '0;
              tr_last  <= '0;
              tr_data  <= '0;
              state    <= S_DONE;
              done     <= 1'b1;
            end else begin
              remaining                      <= remaining - CNT_W'(1);
              cur                            <= nxt_val;
              tr_data[ch_q*DATA_W +: DATA_W] <= nxt_val;
              tr_last[ch_q]                  <= (remaining == CNT_W'(2));
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tr_seq_gen.sv
// Randomised bench for tr_seq_gen: each command's expected beats, reset pulse
// and done timing come from a queue-based model of the command.
module tb_tr_seq_gen;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned RSTC   = 3;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [DATA_W-1:0]        cmd_a;
  logic [CNT_W-1:0]         cmd_b;
  logic [1:0]               cmd_ch;
  logic [1:0]               cmd_mode;
  logic                     cmd_rst;
  logic                     dut_resetn;
  logic [NUM_CH-1:0]        tr_valid;
  logic [NUM_CH-1:0]        tr_ready;
  logic [NUM_CH*DATA_W-1:0] tr_data;
  logic [NUM_CH-1:0]        tr_last;
  logic                     busy;
  logic                     done;

  int checks = 0;
  int errors = 0;

  tr_seq_gen #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_CH(NUM_CH), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_rst(cmd_rst),
    .dut_resetn(dut_resetn),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data), .tr_last(tr_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, 128'(tr_valid), 128'd0);
    chk({tag, " data"}, 128'(tr_data), 128'd0);
    chk({tag, " last"}, 128'(tr_last), 128'd0);
    chk({tag, " busy"}, 128'(busy), 128'd0);
    chk({tag, " done"}, 128'(done), 128'd0);
    chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'd0);
    chk({tag, " dut_resetn"}, 128'(dut_resetn), 128'd0);
  endtask

  // Enter with the DUT idle just after a negedge; leave the same way.
  // rmode: 0 = ready held high, 1 = random, 2 = pattern bits (one per RUN cycle).
  task automatic run_cmd(input logic [31:0] a, input logic [15:0] b, input logic [1:0] ch,
                         input logic [1:0] mode, input bit rst, input int rmode,
                         input logic [15:0] pat, input bit spam, input int abort_after);
    logic [31:0]  q[$];
    logic [31:0]  step;
    logic [127:0] ev;
    logic [2:0]   r;
    int           chc, start_run, done_t, pidx, pops;
    bit           in_run, finished;

    chc       = (ch >= 2'(NUM_CH)) ? NUM_CH - 1 : int'(ch);
    step      = (mode == 2'd0) ? 32'd1 : (mode == 2'd2) ? 32'hFFFF_FFFF : 32'd0;
    for (int i = 0; i < int'(b); i++) q.push_back(32'(a + step * 32'(i)));
    start_run = 1 + (rst ? int'(RSTC) : 0);
    done_t    = (b == 16'd0) ? start_run : 1 << 30;
    pidx      = 0;
    pops      = 0;
    finished  = 0;

    chk("idle cmd_ready", 128'(cmd_ready), 128'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_ch = ch; cmd_mode = mode; cmd_rst = rst;
    tr_ready  = '0;

    for (int t = 1; t < 3000 && !finished; t++) begin
      @(negedge clk);
      if (spam && t < done_t) begin
        cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = 16'($urandom_range(1, 9));
        cmd_ch = 2'($urandom); cmd_mode = 2'($urandom); cmd_rst = 1'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end

      in_run = (t >= start_run) && (q.size() > 0);
      ev = '0;
      if (in_run) ev[chc*32 +: 32] = q[0];
      chk("dut_resetn", 128'(dut_resetn), 128'(!(rst && t <= int'(RSTC))));
      chk("tr_valid", 128'(tr_valid), in_run ? 128'(1) << chc : 128'd0);
      chk("tr_data", 128'(tr_data), ev);
      chk("tr_last", 128'(tr_last), (in_run && q.size() == 1) ? 128'(1) << chc : 128'd0);
      chk("done", 128'(done), 128'(t == done_t));
      chk("busy", 128'(busy), 128'd1);
      chk("cmd_ready busy", 128'(cmd_ready), 128'd0);

      if (t == done_t) begin
        finished = 1;
      end else if (abort_after != 0 && pops == abort_after) begin
        resetn = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        chk_all_zero("held reset");
        cmd_valid = 1'b0;
        tr_ready  = '0;
        resetn    = 1'b1;
        @(negedge clk);
        chk("post reset cmd_ready", 128'(cmd_ready), 128'd1);
        chk("post reset dut_resetn", 128'(dut_resetn), 128'd1);
        chk("post reset valid", 128'(tr_valid), 128'd0);
        return;
      end else begin
        r = 3'($urandom);
        if (rmode == 0) r[chc] = 1'b1;
        else if (rmode == 2) r[chc] = in_run ? pat[pidx] : 1'b0;
        tr_ready = r;
        if (in_run) begin
          pidx++;
          if (r[chc]) begin
            void'(q.pop_front());
            pops++;
            if (q.size() == 0) done_t = t + 1;
          end
        end
      end
    end

    if (!finished) chk("command timeout", 128'd1, 128'd0);
    cmd_valid = 1'b0;
    tr_ready  = '0;
    @(negedge clk);
    chk("back to idle cmd_ready", 128'(cmd_ready), 128'd1);
    chk("back to idle busy", 128'(busy), 128'd0);
    chk("back to idle valid", 128'(tr_valid), 128'd0);
    chk("back to idle done", 128'(done), 128'd0);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_ch = '0;
    cmd_mode = '0; cmd_rst = 1'b0; tr_ready = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset dut_resetn", 128'(dut_resetn), 128'd0);
      chk("reset cmd_ready", 128'(cmd_ready), 128'd0);
      chk("reset valid", 128'(tr_valid), 128'd0);
      chk("reset busy", 128'(busy), 128'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("release dut_resetn", 128'(dut_resetn), 128'd1);
    chk("release cmd_ready", 128'(cmd_ready), 128'd1);
    chk("release valid", 128'(tr_valid), 128'd0);

    // INC burst on channel 2
    run_cmd(32'd10, 16'd4, 2'd2, 2'd0, 1'b0, 0, 16'h0, 1'b0, 0);
    // Reset request then a single CONST beat
    run_cmd(32'h55, 16'd1, 2'd1, 2'd1, 1'b1, 0, 16'h0, 1'b0, 0);
    // DEC across zero with ready pattern 0,1,0,0,1,1
    run_cmd(32'd1, 16'd3, 2'd0, 2'd2, 1'b0, 2, 16'b11_0010, 1'b0, 0);
    // Zero-length command with commands offered while busy
    run_cmd(32'h1234, 16'd0, 2'd1, 2'd0, 1'b0, 1, 16'h0, 1'b1, 0);
    run_cmd(32'h77, 16'd0, 2'd0, 2'd0, 1'b1, 1, 16'h0, 1'b1, 0);
    // Out-of-range channel and reserved mode
    run_cmd(32'hFFFF_FFFE, 16'd4, 2'd3, 2'd3, 1'b0, 1, 16'h0, 1'b0, 0);
    run_cmd(32'hFFFF_FFFE, 16'd4, 2'd3, 2'd0, 1'b0, 0, 16'h0, 1'b0, 0);
    // Async reset after three beats, then a clean restart
    run_cmd(32'd100, 16'd8, 2'd1, 2'd0, 1'b0, 0, 16'h0, 1'b0, 3);
    run_cmd(32'd500, 16'd3, 2'd1, 2'd0, 1'b0, 0, 16'h0, 1'b0, 0);
    // Longer burst under random backpressure
    run_cmd($urandom, 16'd300, 2'd0, 2'd2, 1'b1, 1, 16'h0, 1'b0, 0);

    for (int n = 0; n < 30; n++)
      run_cmd($urandom, 16'($urandom_range(0, 6)), 2'($urandom), 2'($urandom),
              1'($urandom), 1, 16'h0, 1'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tr_seq_gen.md
Name: tr_seq_gen

Overview:
Parametrised, synthesisable transaction sequencer and reset generator that replaces task-based stimulus with RTL.
- Accepts one command at a time: start value, beat count, target channel, data mode, optional DUT-reset request.
- Optionally pulses a DUT soft reset, then streams a counted burst of valid/ready beats on the selected channel out of NUM_CH.
- Sits between the test controller (DPI or CPU-side command source) and the DUT stimulus ports.

Parameters:
DATA_W, 32, width of each beat's data
CNT_W, 16, width of the beat-count field
NUM_CH, 4, number of output channels (must be ≥1)
RST_CYCLES, 1, cycles dut_resetn is held low per reset request (must be ≥1)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_a  in  DATA_W  first beat value
cmd_b  in  CNT_W  number of beats (0 allowed)
cmd_ch  in  max(1,$clog2(NUM_CH))  target channel
cmd_mode  in  2  0=INC, 1=CONST, 2=DEC, 3=reserved (treated as CONST)
cmd_rst  in  1  pulse dut_resetn before the burst
dut_resetn  out  1  generated active-low DUT reset
tr_valid  out  NUM_CH  per-channel beat valid
tr_ready  in  NUM_CH  per-channel beat ready
tr_data  out  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W]
tr_last  out  NUM_CH  final beat of burst
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values (resetn low): state=IDLE, cmd_ready=0, dut_resetn=0, tr_valid=0, tr_data=0, tr_last=0, busy=0, done=0, all counters cleared.
- First posedge after resetn rises: dut_resetn=1, cmd_ready=1.
- All outputs are registered. cmd_ready is 1 only in IDLE.
- States:
  - IDLE: on cmd_valid&&cmd_ready, latch a/b/ch/mode/rst. Next state is RST if cmd_rst=1; else RUN if b≠0; else DONE.
  - RST: dut_resetn=0 for exactly RST_CYCLES cycles, then dut_resetn=1. Next state is RUN if b≠0, else DONE.
  - RUN: tr_valid[ch]=1; all other channels' valid, last and data are 0. tr_data[ch] = current value, starting at a.
    - A beat is accepted on a cycle with tr_valid[ch]&&tr_ready[ch].
    - After each accepted beat the value updates: INC → +1, DEC → −1, CONST → unchanged. Arithmetic is modulo 2^DATA_W (0xFFFFFFFF+1=0; 0−1=0xFFFFFFFF).
    - tr_last[ch]=1 while the remaining count is 1.
    - After the b-th accepted beat, tr_valid drops in the next cycle and the state goes to DONE.
  - DONE: done=1 for one cycle, then IDLE. cmd_ready returns to 1 the cycle after done.
- Handshake rules:
  - Once tr_valid is asserted, tr_data and tr_last stay stable until accepted.
  - tr_valid never depends combinationally on tr_ready.
  - tr_ready on non-selected channels is ignored.
- Back-to-back beats: with tr_ready held high, one beat per cycle. A burst of b beats takes b cycles in RUN.
- Latency: command accept → first tr_valid is 1 cycle without reset request, or RST_CYCLES+1 cycles with one.
- Boundary cases:
  - b=0: no tr_valid, but done still pulses. The reset pulse still occurs if cmd_rst=1.
  - b=2^CNT_W−1: full count with no overflow of the counter.
  - cmd_ch ≥ NUM_CH: clamp to channel NUM_CH−1.
  - cmd_valid while busy is ignored (no latch).
- resetn asserted mid-burst: every output returns asynchronously to its reset value, and any in-flight burst is discarded.

Test Plan:
- Reset/idle: hold resetn low 3 cycles, then release → dut_resetn=0, cmd_ready=0 during reset. First posedge after release: dut_resetn=1, cmd_ready=1, tr_valid=0.
- INC burst, ch=2, a=10, b=4, ready held 1 → tr_data[2] = 10,11,12,13 on consecutive cycles; tr_last on 13; done one cycle after the last beat; other channels' valid=0.
- Reset request, RST_CYCLES=3, cmd_rst=1, b=1, a=0x55, CONST → dut_resetn low exactly 3 cycles, then one beat 0x55 with tr_last=1, then done.
- Backpressure with wrap, DEC, a=1, b=3, tr_ready toggling 0,1,0,0,1,1 → accepted beats 1,0,0xFFFFFFFF. Data and last are stable across stalls.
- b=0, and a second cmd_valid issued while busy → no tr_valid, single done pulse; the ignored command is never executed.
- Async reset mid-burst (INC, b=8, resetn low after 3 beats) → all outputs 0 immediately. A new command after release starts cleanly from its own cmd_a.
